id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU. It latches decoded operands and control from ID. It forwards results from MEM and WB onto the registered operands and drives the ALU inputs SrcA, SrcB and Operation. It also detects load-use hazards and handles bubble insertion, flush and downstream hold.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU operation code width
REG_ADDR, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_WIDTH  PC of ID instruction
id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_ADDR  register indices
id_uses_rs1, id_uses_rs2  in  1  instruction reads rs1/rs2
id_alu_op  in  OPCODE_LENGTH  ALU operation
id_src_a_pc  in  1  1: SrcA=PC, 0: SrcA=rs1
id_src_b_imm  in  1  1: SrcB=imm, 0: SrcB=rs2
id_reg_write, id_mem_read, id_mem_write  in  1  control
mem_reg_write  in  1  MEM instruction writes rd
mem_rd  in  REG_ADDR
mem_result  in  DATA_WIDTH
wb_reg_write  in  1
wb_rd  in  REG_ADDR
wb_result  in  DATA_WIDTH
flush  in  1  squash EX contents (taken branch/jump)
ex_hold  in  1  downstream stall, freeze EX
SrcA, SrcB  out  DATA_WIDTH  ALU operands
Operation  out  OPCODE_LENGTH  ALU operation
store_data  out  DATA_WIDTH  forwarded rs2 for SW
ex_pc  out  DATA_WIDTH
ex_rd  out  REG_ADDR
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1
stall_out  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset (sync, clk edge with reset=1): all EX registers clear to 0, so ex_valid=0, all controls 0, Operation=0000, ex_rd=0. SrcA, SrcB and store_data evaluate to 0.
- Register update priority at each clk edge: reset > flush > ex_hold > load_use > load.
  - flush: insert a bubble. valid, reg_write, mem_read and mem_write go to 0, rd goes to 0, Operation goes to 0000, and data fields go to 0.
  - ex_hold: all fields keep their value, except the stored rs1/rs2 data, which is overwritten with the current forwarded value (fwd_rs1/fwd_rs2). This prevents losing a WB value that retires during the hold.
  - load_use: insert a bubble (as flush).
  - load: capture all id_* fields. A bubble is captured instead if id_valid=0.
- Forwarding, combinational from the registered state:
  - fwd_rs1 = mem_result if mem_reg_write & mem_rd==ex_rs1 & ex_rs1!=0.
  - Otherwise wb_result if wb_reg_write & wb_rd==ex_rs1 & ex_rs1!=0.
  - Otherwise the registered rs1 data.
  - fwd_rs2 uses the same rule on rs2. MEM has priority over WB. x0 is never forwarded.
- Operand select:
  - SrcA = ex_src_a_pc ? ex_pc : fwd_rs1.
  - SrcB = ex_src_b_imm ? ex_imm : fwd_rs2.
  - store_data = fwd_rs2 always.
  - Operation = registered alu_op.
- Load-use hazard: load_use = ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) & id_valid.
- stall_out = (load_use | ex_hold) & ~flush. The flush owner redirects fetch, so no stall is needed under flush.
- Latency: the ID instruction appears on EX outputs 1 cycle after capture. A load-use stall costs exactly one bubble.
- Outputs are purely a function of registers plus the forwarding inputs. There are no combinational paths from id_* to SrcA/SrcB.

Test Plan:
1. Reset held 2 cycles, then ADDI load: id_rs1_data=5, id_imm=7, id_src_b_imm=1, id_alu_op=0011. Required: everything 0 during reset; next cycle SrcA=5, SrcB=7, Operation=0011, ex_valid=1.
2. ex_rs1=3 with mem_reg_write=1, mem_rd=3, mem_result=0xAA and wb_reg_write=1, wb_rd=3, wb_result=0xBB. Required: SrcA=0xAA. Drop the MEM match and SrcA=0xBB.
3. ex_rs1=0 and mem_rd=0 with mem_reg_write=1, mem_result=0xFF. Required: SrcA stays the registered rs1 data (0), no forwarding.
4. EX holds LW with rd=4; ID has ADD with rs2=4, id_uses_rs2=1. Required: stall_out=1 for one cycle, and the next EX is a bubble (ex_valid=0, ex_reg_write=0). The cycle after, ADD loads with stall_out=0.
5. flush=1 together with ex_hold=1 and a valid ID instruction. Required: next cycle ex_valid=0, controls 0, stall_out=0 during the flush cycle.
6. ex_hold=1 for 3 cycles with ex_rs2=6; in the first hold cycle wb_rd=6, wb_result=0x1234, which is gone afterwards. Required: store_data=0x1234 for the remaining hold cycles and after hold releases; stall_out=1 throughout the hold.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Drives the ALU operands, the operation and the forwarded store data from registered state.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_src_a_pc,
  input  logic                     id_src_b_imm,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     mem_reg_write,
  input  logic [REG_ADDR-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic                     wb_reg_write,
  input  logic [REG_ADDR-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  input  logic                     flush,
  input  logic                     ex_hold,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    store_data,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     stall_out
);

  typedef struct packed {
    logic                     valid;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [REG_ADDR-1:0]      rs1;
    logic [REG_ADDR-1:0]      rs2;
    logic [REG_ADDR-1:0]      rd;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     src_a_pc;
    logic                     src_b_imm;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;

  logic [DATA_WIDTH-1:0] fwd_rs1_s;
  logic [DATA_WIDTH-1:0] fwd_rs2_s;
  logic                  load_use_s;

  // Forwarding muxes: MEM beats WB, and x0 is never forwarded.
  always_comb begin
    fwd_rs1_s = ex_q.rs1_data;
    fwd_rs2_s = ex_q.rs2_data;
    if (mem_reg_write && (mem_rd == ex_q.rs1) && (ex_q.rs1 != {REG_ADDR{1'b0}})) begin
      fwd_rs1_s = mem_result;
    end else if (wb_reg_write && (wb_rd == ex_q.rs1) && (ex_q.rs1 != {REG_ADDR{1'b0}})) begin
      fwd_rs1_s = wb_result;
    end else begin
      fwd_rs1_s = ex_q.rs1_data;
    end
    if (mem_reg_write && (mem_rd == ex_q.rs2) && (ex_q.rs2 != {REG_ADDR{1'b0}})) begin
      fwd_rs2_s = mem_result;
    end else if (wb_reg_write && (wb_rd == ex_q.rs2) && (ex_q.rs2 != {REG_ADDR{1'b0}})) begin
      fwd_rs2_s = wb_result;
    end else begin
      fwd_rs2_s = ex_q.rs2_data;
    end
  end

  // Load-use hazard and upstream stall request.
  always_comb begin
    load_use_s = ex_q.valid && ex_q.mem_read && (ex_q.rd != {REG_ADDR{1'b0}}) && id_valid &&
                 ((id_uses_rs1 && (id_rs1 == ex_q.rd)) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));
    stall_out  = (load_use_s || ex_hold) && !flush;
  end

  // Next-state selection: flush > hold > load-use bubble > capture.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (ex_hold) begin
      // Refresh operand data so a WB value retiring mid-hold is not lost.
      ex_d.rs1_data = fwd_rs1_s;
      ex_d.rs2_data = fwd_rs2_s;
    end else if (load_use_s) begin
      ex_d = '0;
    end else if (id_valid) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = id_pc;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.alu_op    = id_alu_op;
      ex_d.src_a_pc  = id_src_a_pc;
      ex_d.src_b_imm = id_src_b_imm;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
    end else begin
      ex_d = '0;
    end
  end

  // EX pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand select and registered control outputs.
  always_comb begin
    SrcA         = ex_q.src_a_pc ? ex_q.pc : fwd_rs1_s;
    SrcB         = ex_q.src_b_imm ? ex_q.imm : fwd_rs2_s;
    store_data   = fwd_rs2_s;
    Operation    = ex_q.alu_op;
    ex_pc        = ex_q.pc;
    ex_rd        = ex_q.rd;
    ex_valid     = ex_q.valid;
    ex_reg_write = ex_q.reg_write;
    ex_mem_read  = ex_q.mem_read;
    ex_mem_write = ex_q.mem_write;
  end

endmodule
